// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
package whack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_UP   = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int LFSR_W    = 8;
    // Taps 8,6,5,4 expressed as a mask over bit indices 7,5,4,3.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;
    localparam int MISS_W    = 4;
    localparam int NUM_HOLES = 4;
    localparam int HOLE_W    = $clog2(NUM_HOLES);

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/whack_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick the next mole hole.
module whack_lfsr
    import whack_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) q <= SEED;
        else       q <= lfsr_next(q);
    end

endmodule

// File: rtl/whack_scorer.sv
// Whack-a-mole round controller: pops moles, times windows, judges whacks, keeps score.
// Optional WHACK_SPEEDUP_EN shortens the mole window every eighth hit.
module whack_scorer
    import whack_pkg::*;
#(
    parameter logic [15:0]       GAP_TICKS  = 16'd50,
    parameter logic [15:0]       MOLE_TICKS = 16'd200,
    parameter int                SCORE_W    = 8,
    parameter int                MAX_MISSES = 3,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [HOLE_W-1:0]  pos,
    input  logic               whack,
    input  logic               start,
    output logic [HOLE_W-1:0]  mole_pos,
    output logic               mole_up,
    output logic [SCORE_W-1:0] score,
    output logic [MISS_W-1:0]  misses,
    output logic               hit_pulse,
    output logic               game_over
);

    localparam int GAP_I = int'(GAP_TICKS);
    localparam int MOLE_I = int'(MOLE_TICKS);
    localparam int MAX_T = (GAP_I > MOLE_I) ? GAP_I : MOLE_I;
    localparam int TW = $clog2(MAX_T + 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_I - 1);
    localparam logic [TW-1:0] WINDOW_INIT = TW'(MOLE_I);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MAX_MISSES);

    state_t              state;
    logic [TW-1:0]       timer;
    logic [TW-1:0]       window;
    logic [LFSR_W-1:0]   lfsr_q;
    logic                unused_lfsr;
    logic                start_game;
    logic                hit;
    logic                miss;
    logic [SCORE_W-1:0]  score_sat;
    logic [MISS_W-1:0]   misses_inc;

    whack_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[LFSR_W-1:HOLE_W];

    // A matching whack always wins, even on the final window cycle.
    assign start_game = ((state == ST_IDLE) || (state == ST_OVER)) && start;
    assign hit        = (state == ST_UP) && whack && (pos == mole_pos);
    assign miss       = (state == ST_UP) && !hit && (whack || (timer == '0));
    assign score_sat  = (score == '1) ? score : score + 1'b1;
    assign misses_inc = misses + 1'b1;

`ifdef WHACK_SPEEDUP_EN
    localparam logic [TW-1:0] WINDOW_MIN = TW'(MOLE_I / 4);

    logic [TW-1:0] window_shrunk;
    assign window_shrunk = window - (window >> 3);

    // Only a hit that actually advances the score onto a multiple of 8 shrinks the window.
    always_ff @(posedge clk) begin
        if (reset || start_game) begin
            window <= WINDOW_INIT;
        end else if (hit && (score_sat != score) && (score_sat[2:0] == 3'd0)) begin
            window <= (window_shrunk < WINDOW_MIN) ? WINDOW_MIN : window_shrunk;
        end
    end
`else
    assign window = WINDOW_INIT;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            timer     <= '0;
            mole_pos  <= '0;
            mole_up   <= 1'b0;
            score     <= '0;
            misses    <= '0;
            hit_pulse <= 1'b0;
            game_over <= 1'b0;
        end else begin
            hit_pulse <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start_game) begin
                        score     <= '0;
                        misses    <= '0;
                        timer     <= GAP_LOAD;
                        game_over <= 1'b0;
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (timer == '0) begin
                        mole_pos <= lfsr_q[HOLE_W-1:0];
                        timer    <= window - 1'b1;
                        mole_up  <= 1'b1;
                        state    <= ST_UP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_UP: begin
                    if (hit) begin
                        score     <= score_sat;
                        hit_pulse <= 1'b1;
                        mole_up   <= 1'b0;
                        timer     <= GAP_LOAD;
                        state     <= ST_GAP;
                    end else if (miss) begin
                        misses  <= misses_inc;
                        mole_up <= 1'b0;
                        timer   <= GAP_LOAD;
                        if (misses_inc == MISS_LIMIT) begin
                            game_over <= 1'b1;
                            state     <= ST_OVER;
                        end else begin
                            state <= ST_GAP;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
